sysid_mc: RTL and testbench
===========================

Name: sysid_mc

Overview:
- Parametrised multicore system-ID peripheral on an Avalon-MM slave. It is the successor to the two-word ID/timestamp block.
- Returns the build ID, the build timestamp and a config word. It adds a 64-bit uptime counter with coherent snapshot reads and a scratch register.
- It also adds a boot-synchronisation barrier for up to 16 Nios cores.
- Sits on the shared system interconnect; every core's data master reaches it.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value returned at register 0.
- TIMESTAMP, 32'd1326413930, build timestamp returned at register 1.
- NUM_CORES, 4, number of barrier participants; legal range 1..16.
- HW_VERSION, 8'd2, version field in CONFIG.
- UPTIME_DIV, 1, uptime increments once every UPTIME_DIV clocks; legal range 1..65535.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- read  in  1  read strobe, one cycle per transfer.
- write  in  1  write strobe, one cycle per transfer.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high exactly one cycle after an accepted read.
- barrier_done  out  1  one-cycle pulse when the barrier completes.

Behaviour:
- The block has one clock and a synchronous active-high reset. All state is clocked on the rising edge of `clock` and cleared when `reset`=1 at an edge.
- Reset values: readdata=0, readdatavalid=0, barrier_done=0, uptime=0, prescaler=0, shadow_hi=0, scratch=0, arrived mask=0, generation=0.
- Read latency is fixed at 1 and waitrequest is never asserted.
  - Read in cycle N: readdatavalid=1 and readdata valid in cycle N+1.
  - readdata holds its last value while readdatavalid=0.
- Register map (word addresses):
  - 0 SYSTEM_ID, RO.
  - 1 TIMESTAMP, RO.
  - 2 CONFIG, RO: [4:0]=NUM_CORES, [15:8]=HW_VERSION, [31:16]=0.
  - 3 UPTIME_LO, RO: returns uptime[31:0]. The same read loads shadow_hi <= uptime[63:32].
  - 4 UPTIME_HI, RO: returns shadow_hi. It never reads the live upper word.
  - 5 SCRATCH, RW: full 32-bit.
  - 6 BARRIER, RW: read returns [15:0]=arrived mask (bits >= NUM_CORES read 0) and [31:16]=generation. Write ORs writedata[NUM_CORES-1:0] into arrived; upper bits are ignored.
  - 7 reserved: reads 0, writes ignored.
- Writes to RO registers are ignored.
- Read and write asserted in the same cycle: the read is served and the write is discarded.
- Uptime:
  - Prescaler counts 0..UPTIME_DIV-1. On each wrap, uptime increments by 1.
  - Uptime is 64-bit and wraps to 0 after all-ones, with no flag.
  - With UPTIME_DIV=1 the prescaler is absent and uptime increments every cycle.
  - A read of UPTIME_LO in cycle N returns the uptime value registered at the start of cycle N (pre-increment). shadow_hi captures the upper word of that same value, so LO/HI form a coherent pair across a carry.
- Barrier:
  - On a write, next_mask = arrived | writedata[NUM_CORES-1:0].
  - If next_mask equals all NUM_CORES bits set:
    - arrived <= 0.
    - generation <= generation+1, modulo 2^16.
    - barrier_done=1 in the following cycle.
  - Otherwise arrived <= next_mask.
  - A write of 0, or of bits that are already set, changes nothing.
  - Re-arrival of a set bit is idempotent.
  - NUM_CORES=1: any write with bit0=1 completes immediately.
- Reset mid-barrier or mid-read:
  - Arrived and generation clear.
  - A read accepted in the same cycle as reset produces no readdatavalid.

Decomposition:
- Package sysid_mc_pkg holds:
  - Register address localparams (REG_SYSID..REG_BARRIER).
  - CONFIG field offsets and widths.
  - MAX_CORES=16.
- Sub-module sysid_uptime_counter (prescaler plus 64-bit counter).
  - Ports: clock, reset, count[63:0].
  - Parameter: UPTIME_DIV.
- The top level holds the register decode, shadow, scratch, barrier and read pipeline.

Test Plan:
1. Reset, then read addresses 0,1,2 with NUM_CORES=4, HW_VERSION=2 -> readdata 0, 1326413930, 32'h0000_0204, each with readdatavalid exactly one cycle after read.
2. Write 32'hDEADBEEF to 5, then read 5 -> 32'hDEADBEEF. Write to 0, then read 0 -> still 0. Read 7 -> 0.
3. Force uptime=64'h0000_0000_FFFF_FFFF, read 3 then 4 several cycles later -> LO=32'hFFFF_FFFF, HI=0, not 1. Second pair: LO small, HI=1.
4. UPTIME_DIV=4: after reset, after 40 clocks, read 3 -> returns 9 or 10 per exact sampling cycle; check the increment cadence is exactly one per 4 clocks.
5. Barrier, NUM_CORES=4:
   - Write 6 with 1, 2, then 2 again, then read 6 -> 32'h0000_0003.
   - Write 32'h0000_001C -> barrier_done pulses once, and a subsequent read of 6 returns 32'h0001_0000.
6. Read and write asserted together on 5 -> read served and scratch unchanged. Assert reset with arrived=3 -> mask=0, generation=0, no barrier_done.

Source files
------------

// File: rtl/sysid_mc_pkg.sv
// Shared definitions for the multicore system-ID peripheral: register map,
// CONFIG field layout, barrier read-word layout and the CONFIG packing helper.
package sysid_mc_pkg;

  localparam int unsigned MAX_CORES = 16;

  // Word addresses of the register map; address 7 is reserved.
  localparam logic [2:0] REG_SYSID     = 3'd0;
  localparam logic [2:0] REG_TIMESTAMP = 3'd1;
  localparam logic [2:0] REG_CONFIG    = 3'd2;
  localparam logic [2:0] REG_UPTIME_LO = 3'd3;
  localparam logic [2:0] REG_UPTIME_HI = 3'd4;
  localparam logic [2:0] REG_SCRATCH   = 3'd5;
  localparam logic [2:0] REG_BARRIER   = 3'd6;

  // CONFIG word layout.
  localparam int unsigned CFG_CORES_LSB = 0;
  localparam int unsigned CFG_CORES_W   = 5;
  localparam int unsigned CFG_VER_LSB   = 8;
  localparam int unsigned CFG_VER_W     = 8;

  // BARRIER read word: generation in the upper half, arrived mask below.
  typedef struct packed {
    logic [15:0] generation;
    logic [15:0] mask;
  } barrier_word_t;

  // Builds the constant CONFIG word from the elaboration parameters.
  function automatic logic [31:0] pack_config(input int unsigned num_cores,
                                              input logic [7:0]  hw_version);
    logic [31:0] w;
    w = '0;
    w[CFG_CORES_LSB +: CFG_CORES_W] = num_cores[CFG_CORES_W-1:0];
    w[CFG_VER_LSB +: CFG_VER_W]     = hw_version;
    return w;
  endfunction

endpackage

// File: rtl/sysid_mc_if.sv
// Avalon-MM slave bus of the system-ID peripheral: fixed read latency of one
// cycle, no waitrequest.
interface sysid_mc_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter, advanced once every UPTIME_DIV clocks.
// With UPTIME_DIV=1 the prescaler is not built and the counter steps every
// cycle. The counter wraps silently after all-ones.
module sysid_uptime_counter #(
  parameter int unsigned UPTIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;
  logic        tick;

  generate
    if (UPTIME_DIV == 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int unsigned PW = $clog2(UPTIME_DIV);
      localparam logic [PW-1:0] PRESC_LAST = PW'(UPTIME_DIV - 1);

      logic [PW-1:0] presc_q, presc_d;

      // Prescaler next state: count 0..UPTIME_DIV-1 and wrap.
      always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        presc_d = presc_q + PW'(1);
        if (presc_q == PRESC_LAST) presc_d = '0;
      end

      // Prescaler register.
      always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
      end

      assign tick = (presc_q == PRESC_LAST);
    end
  endgenerate

  // Uptime next state: advance on each prescaler wrap.
  always_comb begin
    count_d = count_q;
    if (tick) count_d = count_q + 64'd1;
  end

  // Uptime register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sysid_mc.sv
// Multicore system-ID peripheral: read-only ID/timestamp/config words, a
// 64-bit uptime with a coherent LO-then-HI snapshot, a scratch register and a
// boot barrier for up to MAX_CORES cores. Reads return one cycle later.
module sysid_mc
  import sysid_mc_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID  = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP  = 32'd1326413930,
  parameter int unsigned NUM_CORES  = 4,
  parameter logic [7:0]  HW_VERSION = 8'd2,
  parameter int unsigned UPTIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  sysid_mc_if.slave   bus,
  output logic        barrier_done
);

  localparam logic [31:0]          CONFIG_WORD = pack_config(NUM_CORES, HW_VERSION);
  localparam logic [NUM_CORES-1:0] ALL_ARRIVED = '1;

  logic [63:0]          uptime;
  logic [31:0]          rd_word;
  logic [NUM_CORES-1:0] next_mask;
  barrier_word_t        barrier_word;

  logic [31:0]          readdata_q, readdata_d;
  logic                 rdv_q, rdv_d;
  logic [31:0]          shadow_hi_q, shadow_hi_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [NUM_CORES-1:0] arrived_q, arrived_d;
  logic [15:0]          gen_q, gen_d;
  logic                 done_q, done_d;

  sysid_uptime_counter #(
    .UPTIME_DIV (UPTIME_DIV)
  ) u_uptime (
    .clock (clock),
    .reset (reset),
    .count (uptime)
  );

  // Read mux: selects the word returned for the current address.
  always_comb begin
    barrier_word.generation = gen_q;
    barrier_word.mask       = 16'(arrived_q);
    rd_word = '0;
    case (bus.address)
      REG_SYSID:     rd_word = SYSTEM_ID;
      REG_TIMESTAMP: rd_word = TIMESTAMP;
      REG_CONFIG:    rd_word = CONFIG_WORD;
      REG_UPTIME_LO: rd_word = uptime[31:0];
      REG_UPTIME_HI: rd_word = shadow_hi_q;
      REG_SCRATCH:   rd_word = scratch_q;
      REG_BARRIER:   rd_word = barrier_word;
      default:       rd_word = '0;
    endcase
  end

  // Next-state: read pipeline, LO-read snapshot, scratch and barrier writes.
  // A read in the same cycle as a write wins and the write is dropped.
  always_comb begin
    readdata_d  = readdata_q;
    rdv_d       = 1'b0;
    shadow_hi_d = shadow_hi_q;
    scratch_d   = scratch_q;
    arrived_d   = arrived_q;
    gen_d       = gen_q;
    done_d      = 1'b0;
    next_mask   = arrived_q | bus.writedata[NUM_CORES-1:0];

    if (bus.read) begin
      rdv_d      = 1'b1;
      readdata_d = rd_word;
      // Capture the upper word of the same value whose lower word is returned,
      // so a later HI read pairs coherently even across a carry.
      if (bus.address == REG_UPTIME_LO) shadow_hi_d = uptime[63:32];
    end else if (bus.write) begin
      case (bus.address)
        REG_SCRATCH: scratch_d = bus.writedata;
        REG_BARRIER: begin
          if (next_mask == ALL_ARRIVED) begin
            arrived_d = '0;
            gen_d     = gen_q + 16'd1;
            done_d    = 1'b1;
          end else begin
            arrived_d = next_mask;
          end
        end
        default: ;
      endcase
    end
  end

  // Register bank with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_q  <= '0;
      rdv_q       <= 1'b0;
      shadow_hi_q <= '0;
      scratch_q   <= '0;
      arrived_q   <= '0;
      gen_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      rdv_q       <= rdv_d;
      shadow_hi_q <= shadow_hi_d;
      scratch_q   <= scratch_d;
      arrived_q   <= arrived_d;
      gen_q       <= gen_d;
      done_q      <= done_d;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdv_q;
  assign barrier_done      = done_q;

endmodule

// File: tb/tb_sysid_mc.sv
// Scoreboard bench for sysid_mc: drivers push expected read words with the
// cycle they are due; per-instance monitors pop and compare on readdatavalid.
module tb_sysid_mc;
  import sysid_mc_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic done_a, done_b;
  int   cyc = 0;
  int   rst_cyc = 0;
  int   rel_cyc = 0;
  int   done_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [63:0] up_exp;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sysid_mc_if bus_a ();
  sysid_mc_if bus_b ();

  sysid_mc #(
    .NUM_CORES  (4),
    .HW_VERSION (8'd2),
    .UPTIME_DIV (1)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus_a),
    .barrier_done (done_a)
  );

  sysid_mc #(
    .UPTIME_DIV (4)
  ) u_div4 (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus_b),
    .barrier_done (done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor for the UPTIME_DIV=1 instance.
  always @(negedge clock) begin
    exp_t e;
    if (bus_a.readdatavalid === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_rdv", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check({e.name, "_data"}, bus_a.readdata, e.data);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Monitor for the UPTIME_DIV=4 instance.
  always @(negedge clock) begin
    exp_t e;
    if (bus_b.readdatavalid === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_rdv", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check({e.name, "_data"}, bus_b.readdata, e.data);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clock) if (done_a === 1'b1) done_cnt++;

  task automatic idle_all();
    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.writedata = '0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.writedata = '0;
  endtask

  // One bus cycle; starts and ends just after a falling edge.
  task automatic bus_op(input bit b, input logic rd_en, input logic wr_en,
                        input logic [2:0] addr, input logic [31:0] wdata);
    if (b) begin
      bus_b.read = rd_en; bus_b.write = wr_en; bus_b.address = addr; bus_b.writedata = wdata;
    end else begin
      bus_a.read = rd_en; bus_a.write = wr_en; bus_a.address = addr; bus_a.writedata = wdata;
    end
    @(negedge clock);
    idle_all();
  endtask

  task automatic rd(input bit b, input logic [2:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.due  = cyc + 1;
    e.name = name;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    bus_op(b, 1'b1, 1'b0, addr, '0);
  endtask

  task automatic wr(input bit b, input logic [2:0] addr, input logic [31:0] data);
    bus_op(b, 1'b0, 1'b1, addr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_readdata", bus_a.readdata, 32'd0);
    check("rst_rdv", {31'd0, bus_a.readdatavalid}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    reset = 1'b0;
    rst_cyc = cyc;

    // Identity and config words.
    rd(0, REG_SYSID,     32'h0000_0000,  "sysid");
    rd(0, REG_TIMESTAMP, 32'd1326413930, "timestamp");
    rd(0, REG_CONFIG,    32'h0000_0204,  "config");

    // Scratch, RO write protection, reserved address.
    wr(0, REG_SCRATCH, 32'hDEAD_BEEF);
    rd(0, REG_SCRATCH, 32'hDEAD_BEEF, "scratch");
    wr(0, REG_SYSID, 32'hFFFF_FFFF);
    rd(0, REG_SYSID, 32'h0000_0000, "sysid_ro");
    rd(0, 3'd7, 32'd0, "reserved");
    wr(0, 3'd7, 32'h1234_5678);
    rd(0, 3'd7, 32'd0, "reserved_wr");

    // Uptime from reset counts one per cycle.
    rd(0, REG_UPTIME_LO, 32'(cyc - rst_cyc), "uptime_lo0");
    rd(0, REG_UPTIME_HI, 32'd0, "uptime_hi0");

    // Coherent LO/HI pair across a 32-bit carry.
    force u_dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
    @(negedge clock);
    release u_dut.u_uptime.count_q;
    rel_cyc = cyc;
    rd(0, REG_UPTIME_LO, 32'hFFFF_FFFF, "pair1_lo");
    repeat (3) @(negedge clock);
    rd(0, REG_UPTIME_HI, 32'd0, "pair1_hi");
    up_exp = 64'h0000_0000_FFFF_FFFF + 64'(cyc - rel_cyc);
    rd(0, REG_UPTIME_LO, up_exp[31:0], "pair2_lo");
    rd(0, REG_UPTIME_HI, up_exp[63:32], "pair2_hi");
    check("pair2_hi_is_one", up_exp[63:32], 32'd1);

    // UPTIME_DIV=4 cadence: consecutive reads step once per four clocks.
    while (cyc - rst_cyc < 40) @(negedge clock);
    for (int i = 0; i < 6; i++)
      rd(1, REG_UPTIME_LO, 32'((cyc - rst_cyc) / 4), "div4_lo");
    rd(1, REG_UPTIME_HI, 32'd0, "div4_hi");

    // Barrier: partial arrivals, idempotent re-arrival, completion.
    wr(0, REG_BARRIER, 32'h1);
    wr(0, REG_BARRIER, 32'h2);
    wr(0, REG_BARRIER, 32'h2);
    wr(0, REG_BARRIER, 32'h0);
    rd(0, REG_BARRIER, 32'h0000_0003, "barrier_partial");
    check("barrier_no_done", 32'(done_cnt), 32'd0);
    wr(0, REG_BARRIER, 32'h0000_001C);
    repeat (3) @(negedge clock);
    check("barrier_done_once", 32'(done_cnt), 32'd1);
    rd(0, REG_BARRIER, 32'h0001_0000, "barrier_gen1");

    // Simultaneous read and write: read served, write dropped.
    rd(0, 3'd0, 32'd0, "dummy");
    begin
      exp_t e;
      e.data = 32'hDEAD_BEEF; e.due = cyc + 1; e.name = "rw_collide";
      q_a.push_back(e);
      bus_op(0, 1'b1, 1'b1, REG_SCRATCH, 32'h1234_5678);
    end
    rd(0, REG_SCRATCH, 32'hDEAD_BEEF, "scratch_after_rw");

    // Reset mid-barrier with a read in the reset cycle.
    wr(0, REG_BARRIER, 32'h3);
    rd(0, REG_BARRIER, 32'h0001_0003, "barrier_pre_reset");
    reset = 1'b1;
    bus_op(0, 1'b1, 1'b0, REG_BARRIER, '0);
    check("reset_read_no_rdv", {31'd0, bus_a.readdatavalid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rd(0, REG_BARRIER, 32'h0000_0000, "barrier_after_reset");
    repeat (3) @(negedge clock);
    check("reset_no_done", 32'(done_cnt), 32'd1);

    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
